// File: rtl/ifetch_queue_pkg.sv
// Shared instruction-fetch-queue constants: default widths, queue depth and reset PC.
// Imported by the fetch queue top and its storage sub-module.
package ifetch_queue_pkg;

   localparam int IFQ_ADDR_W  = 32;
   localparam int IFQ_INSTR_W = 32;
   localparam int IFQ_DEPTH   = 4;
   localparam logic [IFQ_ADDR_W-1:0] IFQ_RESET_PC = '0;

   // Occupancy counters need one extra bit so that "full" (== DEPTH) is representable.
   function automatic int ifq_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ifetch_queue_fifo_sync.sv
// Single-clock FIFO with synchronous flush and occupancy count; the head entry is read
// straight from the storage registers so the consumer sees registered values.
module fifo_sync
   import ifetch_queue_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = ifq_cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign do_pop  = pop && (cnt != '0);
   // A flush discards whatever would have been written this cycle as well.
   assign do_push = push && (!full || do_pop) && !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign valid = (cnt != '0);
   assign count = cnt;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential reads to a 1-cycle synchronous instruction RAM,
// buffers {pc, instr} responses for decode, and handles redirects by flushing and killing.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int ADDR_W  = IFQ_ADDR_W,
   parameter int INSTR_W = IFQ_INSTR_W,
   parameter int DEPTH   = IFQ_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_addr,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic [INSTR_W-1:0]       imem_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INSTR_W-1:0]       out_instr,
   output logic [ADDR_W-1:0]        out_pc,
   output logic [$clog2(DEPTH):0]   out_count
);

   localparam int CNT_W = ifq_cnt_w(DEPTH);
   localparam int Q_W   = ADDR_W + INSTR_W;
   localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(INSTR_W / 8);
   localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(DEPTH);

   // Sequential successor; the adder simply drops the carry so the PC wraps at 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

   logic [ADDR_W-1:0] fetch_pc_p0;
   logic [ADDR_W-1:0] rsp_pc_p1;
   logic              vld_p1;
   logic [CNT_W-1:0]  q_count;
   logic              q_valid;
   logic [Q_W-1:0]    q_rdata;
   logic              credit_ok;
   logic              issue;
   logic              push;
   logic              pop;

   // ---- p0: address select and issue ----
   assign imem_addr = redirect_valid ? redirect_addr : fetch_pc_p0;

   // The in-flight response already owns a slot, so a push can never find the queue full.
   assign credit_ok = ({1'b0, q_count} + (CNT_W + 1)'(vld_p1)) < DEPTH_LIM;
   assign issue     = en && !reset && credit_ok;
   assign imem_req  = issue;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_p0 <= RESET_PC;
         vld_p1      <= 1'b0;
      end else begin
         vld_p1 <= issue;
         if (issue)
            fetch_pc_p0 <= pc_advance(imem_addr);
         else if (redirect_valid)
            fetch_pc_p0 <= redirect_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) rsp_pc_p1 <= imem_addr;
   end

   // ---- p1: RAM data returns; a redirect now kills it and flushes the queue ----
   assign push = vld_p1 && !redirect_valid;
   assign pop  = q_valid && out_ready;

   fifo_sync #(
      .WIDTH (Q_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata ({rsp_pc_p1, imem_rdata}),
      .rdata (q_rdata),
      .valid (q_valid),
      .count (q_count)
   );

   // ---- p2: registered queue head to decode ----
   assign out_valid           = q_valid;
   assign {out_pc, out_instr} = q_rdata;
   assign out_count           = q_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ifetch_queue;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               en = 1'b0;
   logic               redirect_valid = 1'b0;
   logic [ADDR_W-1:0]  redirect_addr = '0;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic [CNT_W-1:0]   out_count;

   int checks = 0;
   int errors = 0;

   ifetch_queue #(
      .ADDR_W   (ADDR_W),
      .INSTR_W  (INSTR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_count      (out_count)
   );

   always #5 clk = ~clk;

   function automatic logic [INSTR_W-1:0] ram(input logic [ADDR_W-1:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   always @(posedge clk) begin
      if (imem_req) imem_rdata <= ram(imem_addr);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: fetch PC, one optional in-flight request, and a queue of PCs.
   logic [ADDR_W-1:0] m_pc = RESET_PC;
   bit                m_infl = 1'b0;
   logic [ADDR_W-1:0] m_infl_pc = '0;
   logic [ADDR_W-1:0] q[$];

   always @(negedge clk) begin : compare
      logic [ADDR_W-1:0] exp_addr;
      bit                exp_req;
      if (reset) begin
         m_pc   = RESET_PC;
         m_infl = 1'b0;
         q.delete();
         check("m_rst_valid", 64'(out_valid), 64'(0));
         check("m_rst_count", 64'(out_count), 64'(0));
         check("m_rst_req", 64'(imem_req), 64'(0));
      end else begin
         exp_addr = redirect_valid ? redirect_addr : m_pc;
         exp_req  = en && ((q.size() + int'(m_infl)) < DEPTH);
         check("m_count", 64'(out_count), 64'(q.size()));
         check("m_valid", 64'(out_valid), 64'(q.size() > 0));
         check("m_req", 64'(imem_req), 64'(exp_req));
         check("m_addr", 64'(imem_addr), 64'(exp_addr));
         if (q.size() > 0) begin
            check("m_pc", 64'(out_pc), 64'(q[0]));
            check("m_instr", 64'(out_instr), 64'(ram(q[0])));
            if (out_ready) void'(q.pop_front());
         end
         if (redirect_valid) q.delete();
         else if (m_infl) q.push_back(m_infl_pc);
         if (exp_req) begin
            m_infl    = 1'b1;
            m_infl_pc = exp_addr;
            m_pc      = exp_addr + ADDR_W'(INSTR_W / 8);
         end else begin
            m_infl = 1'b0;
            if (redirect_valid) m_pc = redirect_addr;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      tick();
      reset = 1'b1;
      en = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int issued;
      int bad;
      logic [ADDR_W-1:0] popped[$];
      logic [23:0] en_pat;
      logic [23:0] rdy_pat;
      logic [23:0] rd_pat;

      // Reset takes effect with no clock edge.
      #1 reset = 1'b1;
      #1;
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_count", 64'(out_count), 64'(0));
      check("rst_req", 64'(imem_req), 64'(0));
      tick();
      tick();

      // Streaming: addresses 0,4,8,...; first output two cycles after first issue.
      reset = 1'b0;
      en = 1'b1;
      out_ready = 1'b1;
      #1;
      check("a_req0", 64'(imem_req), 64'(1));
      check("a_addr0", 64'(imem_addr), 64'(0));
      for (int k = 1; k < 8; k++) begin
         tick();
         #1;
         check("a_addr", 64'(imem_addr), 64'(4 * k));
         if (k == 1) check("a_valid1", 64'(out_valid), 64'(0));
         if (k >= 2) begin
            check("a_valid", 64'(out_valid), 64'(1));
            check("a_out_pc", 64'(out_pc), 64'(4 * (k - 2)));
            check("a_out_instr", 64'(out_instr), 64'(ram(ADDR_W'(4 * (k - 2)))));
         end
      end

      // Back-pressure: exactly DEPTH requests, then one pop buys exactly one more.
      restart();
      en = 1'b1;
      out_ready = 1'b0;
      issued = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (imem_req) issued++;
         tick();
      end
      #1;
      check("b_issued", 64'(issued), 64'(4));
      check("b_count_full", 64'(out_count), 64'(4));
      check("b_req_full", 64'(imem_req), 64'(0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      issued = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (imem_req) issued++;
         tick();
      end
      #1;
      check("b_issued_after_pop", 64'(issued), 64'(1));
      check("b_count_refill", 64'(out_count), 64'(4));

      // Redirect to 0x100 while fetching 0x10, coinciding with a pop and a push.
      restart();
      en = 1'b1;
      out_ready = 1'b1;
      popped.delete();
      for (int k = 0; k < 4; k++) begin
         #1;
         if (out_valid) popped.push_back(out_pc);
         tick();
      end
      redirect_valid = 1'b1;
      redirect_addr = 32'h100;
      #1;
      check("c_fetch_0x10", 64'(dut.fetch_pc_p0), 64'(32'h10));
      check("c_bypass", 64'(imem_addr), 64'(32'h100));
      check("c_req", 64'(imem_req), 64'(1));
      check("f_head_pc", 64'(out_pc), 64'(32'h8));
      check("f_count", 64'(out_count), 64'(1));
      if (out_valid) popped.push_back(out_pc);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("f_count_flushed", 64'(out_count), 64'(0));
      check("f_valid_flushed", 64'(out_valid), 64'(0));
      tick();
      #1;
      check("c_valid_after", 64'(out_valid), 64'(1));
      check("c_pc_after", 64'(out_pc), 64'(32'h100));
      for (int k = 0; k < 4; k++) begin
         if (out_valid) popped.push_back(out_pc);
         tick();
         #1;
      end
      bad = 0;
      foreach (popped[i]) if (popped[i] == 32'hC || popped[i] == 32'h10) bad++;
      check("c_killed_absent", 64'(bad), 64'(0));

      // en=0: in-flight response still lands, redirect still updates the PC and flushes.
      en = 1'b0;
      out_ready = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_addr = 32'h40;
      #1;
      check("d_en0_req", 64'(imem_req), 64'(0));
      check("d_en0_bypass", 64'(imem_addr), 64'(32'h40));
      tick();
      redirect_valid = 1'b0;
      #1;
      check("d_pc_updated", 64'(imem_addr), 64'(32'h40));
      check("d_count_flushed", 64'(out_count), 64'(0));

      // Back-to-back redirects: only the second target survives.
      en = 1'b1;
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr = 32'h300;
      tick();
      redirect_addr = 32'h400;
      #1;
      check("d_b2b_addr", 64'(imem_addr), 64'(32'h400));
      tick();
      redirect_valid = 1'b0;
      tick();
      #1;
      check("d_b2b_valid", 64'(out_valid), 64'(1));
      check("d_b2b_pc", 64'(out_pc), 64'(32'h400));

      // Address wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_addr = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("d_wrap_addr", 64'(imem_addr), 64'(0));
      check("d_wrap_req", 64'(imem_req), 64'(1));

      // Mixed enable / ready / redirect pattern, checked by the model only.
      en_pat  = 24'hF7EFBF;
      rdy_pat = 24'h9A5C3E;
      rd_pat  = 24'h041200;
      tick();
      for (int k = 0; k < 24; k++) begin
         en = en_pat[k];
         out_ready = rdy_pat[k];
         redirect_valid = rd_pat[k];
         redirect_addr = 32'h800 + 32'(k) * 32'h20;
         tick();
      end
      redirect_valid = 1'b0;

      // Reset mid-operation with three queued entries and one request in flight.
      restart();
      en = 1'b1;
      out_ready = 1'b0;
      repeat (4) tick();
      #1;
      check("e_count3", 64'(out_count), 64'(3));
      check("e_inflight", 64'(dut.vld_p1), 64'(1));
      #1;
      reset = 1'b1;
      #1;
      check("e_async_valid", 64'(out_valid), 64'(0));
      check("e_async_count", 64'(out_count), 64'(0));
      check("e_async_req", 64'(imem_req), 64'(0));
      tick();
      reset = 1'b0;
      #1;
      check("e_first_addr", 64'(imem_addr), 64'(RESET_PC));
      check("e_first_req", 64'(imem_req), 64'(1));
      tick();
      #1;
      check("e_second_addr", 64'(imem_addr), 64'(RESET_PC + 4));
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
